mips_mc_sequencer: RTL and testbench

Multi-cycle control sequencer for the 8-bit MIPS datapath inside `user_proj_example`. It fetches each 32-bit instruction as four byte reads, decodes `op`/`funct`, and drives every datapath select, enable and write strobe through execute, memory and writeback. It replaces the current controller in `mips`; all port names match the datapath's control inputs. It adds `instr_done`, `illegal` and `state_dbg` for test and bring-up.

---
 rtl/mips_mc_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_mips_mc_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_sequencer.sv
// Multi-cycle control sequencer for the 8-bit MIPS datapath: four byte fetches, decode,
// then execute/memory/writeback. Every output is combinational from state, op, funct and zero.
//
// state    | meaning
// ---------+------------------------------------------------------------
// FETCH1-4 | read instruction byte n into IR, PC += 1
// DECODE   | precompute branch target into ALUOut, dispatch on op
// MEMADR   | ALUOut <= A + imm for LB/SB
// LBRD     | read data memory at ALUOut
// LBWR     | write loaded byte to rt
// SBWR     | write B to data memory at ALUOut
// RTYPEEX  | ALU op on A, B selected by funct
// RTYPEWR  | write ALUOut to rd
// BEQEX    | compare A, B; load PC from ALUOut when equal
// JEX      | load PC with imm x 4
// ADDIEX   | ALUOut <= A + imm
// ADDIWR   | write ALUOut to rt
module mips_mc_sequencer #(
  parameter int STATEBITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 alusrca,
  output logic                 memtoreg,
  output logic                 iord,
  output logic                 pcen,
  output logic                 regwrite,
  output logic                 regdst,
  output logic [1:0]           pcsrc,
  output logic [1:0]           alusrcb,
  output logic [2:0]           alucontrol,
  output logic [3:0]           irwrite,
  output logic                 instr_done,
  output logic                 illegal,
  output logic [STATEBITS-1:0] state_dbg
);

  typedef enum logic [STATEBITS-1:0] {
    FETCH1  = STATEBITS'(0),
    FETCH2  = STATEBITS'(1),
    FETCH3  = STATEBITS'(2),
    FETCH4  = STATEBITS'(3),
    DECODE  = STATEBITS'(4),
    MEMADR  = STATEBITS'(5),
    LBRD    = STATEBITS'(6),
    LBWR    = STATEBITS'(7),
    SBWR    = STATEBITS'(8),
    RTYPEEX = STATEBITS'(9),
    RTYPEWR = STATEBITS'(10),
    BEQEX   = STATEBITS'(11),
    JEX     = STATEBITS'(12),
    ADDIEX  = STATEBITS'(13),
    ADDIWR  = STATEBITS'(14)
  } state_e;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH1;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = FETCH1;
    memread    = 1'b0;
    memwrite   = 1'b0;
    alusrca    = 1'b0;
    memtoreg   = 1'b0;
    iord       = 1'b0;
    pcen       = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    pcsrc      = 2'b00;
    alusrcb    = 2'b00;
    alucontrol = 3'b000;
    irwrite    = 4'b0000;
    instr_done = 1'b0;
    illegal    = 1'b0;
    // Reset leaves every strobe at its default of 0, even over FETCH1.
    if (!reset) begin
      case (state_q)
        FETCH1, FETCH2, FETCH3, FETCH4: begin
          memread    = 1'b1;
          irwrite    = 4'b0001 << state_q[1:0];
          alusrcb    = 2'b01;
          alucontrol = ALU_ADD;
          pcen       = 1'b1;
          state_d    = state_e'(state_q + STATEBITS'(1));
        end
        DECODE: begin
          alusrcb    = 2'b11;
          alucontrol = ALU_ADD;
          case (op)
            OP_LB, OP_SB: state_d = MEMADR;
            OP_RTYPE:     state_d = RTYPEEX;
            OP_BEQ:       state_d = BEQEX;
            OP_J:         state_d = JEX;
            OP_ADDI:      state_d = ADDIEX;
            default: begin
              illegal    = 1'b1;
              instr_done = 1'b1;
              state_d    = FETCH1;
            end
          endcase
        end
        MEMADR: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_ADD;
          state_d    = (op == OP_LB) ? LBRD : SBWR;
        end
        LBRD: begin
          memread = 1'b1;
          iord    = 1'b1;
          state_d = LBWR;
        end
        LBWR: begin
          regwrite   = 1'b1;
          memtoreg   = 1'b1;
          instr_done = 1'b1;
        end
        SBWR: begin
          memwrite   = 1'b1;
          iord       = 1'b1;
          instr_done = 1'b1;
        end
        RTYPEEX: begin
          alusrca = 1'b1;
          state_d = RTYPEWR;
          case (funct)
            6'b100000: alucontrol = ALU_ADD;
            6'b100010: alucontrol = ALU_SUB;
            6'b100100: alucontrol = ALU_AND;
            6'b100101: alucontrol = ALU_OR;
            6'b101010: alucontrol = ALU_SLT;
            default: begin
              alucontrol = ALU_ADD;
              illegal    = 1'b1;
              instr_done = 1'b1;
              state_d    = FETCH1;
            end
          endcase
        end
        RTYPEWR: begin
          regdst     = 1'b1;
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        BEQEX: begin
          alusrca    = 1'b1;
          alucontrol = ALU_SUB;
          pcsrc      = 2'b01;
          pcen       = zero;
          instr_done = 1'b1;
        end
        JEX: begin
          pcsrc      = 2'b10;
          pcen       = 1'b1;
          instr_done = 1'b1;
        end
        ADDIEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_ADD;
          state_d    = ADDIWR;
        end
        ADDIWR: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: state_d = FETCH1;
      endcase
    end
  end

  assign state_dbg = reset ? '0 : state_q;

endmodule

// File: tb/tb_mips_mc_sequencer.sv
// Bench for mips_mc_sequencer: directed and random instructions, each cycle's full control
// vector compared against a step-indexed model of the instruction's expected behaviour.
module tb_mips_mc_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst;
  logic [1:0] pcsrc, alusrcb;
  logic [2:0] alucontrol;
  logic [3:0] irwrite;
  logic       instr_done, illegal;
  logic [3:0] state_dbg;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst;
    logic [1:0] pcsrc, alusrcb;
    logic [2:0] alucontrol;
    logic [3:0] irwrite;
    logic       instr_done, illegal;
    logic [3:0] state_dbg;
  } ctl_t;

  ctl_t act;
  int   n_checks = 0;
  int   n_errors = 0;

  mips_mc_sequencer #(.STATEBITS(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .memtoreg(memtoreg),
    .iord(iord), .pcen(pcen), .regwrite(regwrite), .regdst(regdst), .pcsrc(pcsrc),
    .alusrcb(alusrcb), .alucontrol(alucontrol), .irwrite(irwrite),
    .instr_done(instr_done), .illegal(illegal), .state_dbg(state_dbg)
  );

  assign act = {memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst,
                pcsrc, alusrcb, alucontrol, irwrite, instr_done, illegal, state_dbg};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ALU code for a supported funct, -1 otherwise
  function automatic int alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return -1;
    endcase
  endfunction

  function automatic bit is_legal_op(input logic [5:0] o);
    return o == OP_LB || o == OP_SB || o == OP_RTYPE || o == OP_BEQ || o == OP_J || o == OP_ADDI;
  endfunction

  function automatic int n_steps(input logic [5:0] o, input logic [5:0] f);
    if (o == OP_LB) return 8;
    if (o == OP_SB || o == OP_ADDI) return 7;
    if (o == OP_RTYPE) return (alu_of(f) < 0) ? 6 : 7;
    if (o == OP_BEQ || o == OP_J) return 6;
    return 5;
  endfunction

  // Expected control vector at cycle s (0 = FETCH1) of an instruction.
  function automatic ctl_t model(input logic [5:0] o, input logic [5:0] f, input int s,
                                 input logic z);
    ctl_t e;
    logic [3:0] one;
    e = '0;
    one = 4'b0001;
    if (s < 4) begin
      e.memread = 1; e.irwrite = one << s; e.alusrcb = 2'b01; e.alucontrol = 3'b010;
      e.pcen = 1; e.state_dbg = 4'(s);
    end else if (s == 4) begin
      e.state_dbg = 4; e.alusrcb = 2'b11; e.alucontrol = 3'b010;
      e.illegal = !is_legal_op(o);
    end else if (o == OP_LB || o == OP_SB) begin
      if (s == 5) begin
        e.state_dbg = 5; e.alusrca = 1; e.alusrcb = 2'b10; e.alucontrol = 3'b010;
      end else if (o == OP_SB) begin
        e.state_dbg = 8; e.memwrite = 1; e.iord = 1;
      end else if (s == 6) begin
        e.state_dbg = 6; e.memread = 1; e.iord = 1;
      end else begin
        e.state_dbg = 7; e.regwrite = 1; e.memtoreg = 1;
      end
    end else if (o == OP_RTYPE) begin
      if (s == 5) begin
        e.state_dbg = 9; e.alusrca = 1;
        e.alucontrol = (alu_of(f) < 0) ? 3'b010 : 3'(alu_of(f));
        e.illegal = alu_of(f) < 0;
      end else begin
        e.state_dbg = 10; e.regdst = 1; e.regwrite = 1;
      end
    end else if (o == OP_BEQ) begin
      e.state_dbg = 11; e.alusrca = 1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = z;
    end else if (o == OP_J) begin
      e.state_dbg = 12; e.pcsrc = 2'b10; e.pcen = 1;
    end else if (s == 5) begin
      e.state_dbg = 13; e.alusrca = 1; e.alusrcb = 2'b10; e.alucontrol = 3'b010;
    end else begin
      e.state_dbg = 14; e.regwrite = 1;
    end
    e.instr_done = (s == n_steps(o, f) - 1);
    return e;
  endfunction

  // Called just after a rising edge with the DUT in FETCH1. zmode 0/1 fixes zero, 2 randomizes
  // it per cycle; rst_at >= 0 asserts reset in that cycle and abandons the instruction.
  task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn, input int zmode,
                           input int rst_at);
    int len;
    logic z;
    len = n_steps(iop, ifn);
    for (int s = 0; s < len; s++) begin
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      zero = z;
      if (s < 4) begin
        op = 6'($urandom); funct = 6'($urandom);
      end else begin
        op = iop; funct = ifn;
      end
      if (s == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        check_eq($sformatf("reset_mid op%b s%0d", iop, s), 32'(act), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      @(negedge clk);
      check_eq($sformatf("op%b fn%b s%0d", iop, ifn, s), 32'(act), 32'(model(iop, ifn, s, z)));
      @(posedge clk); #1;
    end
  endtask

  logic [5:0] r_op, r_fn;
  logic [5:0] good_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    repeat (3) begin
      @(negedge clk);
      check_eq("reset_hold", 32'(act), 32'd0);
      @(posedge clk);
    end
    #1 reset = 1'b0;

    run_instr(OP_LB, 6'b000000, 2, -1);
    run_instr(OP_SB, 6'b111111, 2, -1);
    run_instr(OP_RTYPE, 6'b100101, 2, -1);
    run_instr(OP_RTYPE, 6'b101010, 2, -1);
    run_instr(OP_BEQ, 6'b000000, 1, -1);
    run_instr(OP_BEQ, 6'b000000, 0, -1);
    run_instr(OP_J, 6'b000000, 2, -1);
    run_instr(OP_ADDI, 6'b000000, 2, -1);
    run_instr(6'b111111, 6'b000000, 2, -1);
    run_instr(OP_RTYPE, 6'b000000, 2, -1);
    run_instr(OP_LB, 6'b000000, 2, 6);
    run_instr(OP_LB, 6'b000000, 2, -1);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 6))
        0: r_op = OP_LB;
        1: r_op = OP_SB;
        2: r_op = OP_RTYPE;
        3: r_op = OP_BEQ;
        4: r_op = OP_J;
        5: r_op = OP_ADDI;
        default: begin
          r_op = 6'($urandom);
          while (is_legal_op(r_op)) r_op = 6'($urandom);
        end
      endcase
      r_fn = $urandom_range(0, 1) ? good_fn[$urandom_range(0, 4)] : 6'($urandom);
      run_instr(r_op, r_fn, 2,
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, n_steps(r_op, r_fn) - 1))
                                             : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
